// File: rtl/iso_lane_steer_gen2.sv
// Isochronous main-stream lane steering: frames each line with BE/BS and deals pixel bytes round-robin over 1..MAX_LANES lanes.
// Optional feature macro: ISO_STEER_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module iso_lane_steer_gen2 #(
    parameter int         PIX_W     = 48,
    parameter int         MAX_LANES = 4,
    parameter logic [7:0] SYM_BE    = 8'hFB,
    parameter logic [7:0] SYM_BS    = 8'hBC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   steer_en,
    input  logic [1:0]             lane_sel,
    input  logic [PIX_W-1:0]       pix_data,
    input  logic                   pix_vld,
    input  logic                   pix_last,
    output logic                   pix_rdy,
    output logic [MAX_LANES*8-1:0] lane_sym,
    output logic [MAX_LANES-1:0]   lane_ctrl,
    output logic                   sym_vld,
`ifdef ISO_STEER_UNDERRUN_CNT_EN
    output logic [15:0]            underrun_cnt,
`endif
    output logic                   line_busy
);

    localparam int PIX_BYTES = PIX_W / 8;
    localparam int BUF_BYTES = 2 * ((PIX_BYTES > MAX_LANES) ? PIX_BYTES : MAX_LANES);
    localparam int BUF_W     = BUF_BYTES * 8;
    localparam int FILL_W    = $clog2(BUF_BYTES + 1);
    localparam int LCNT_W    = $clog2(MAX_LANES + 1);

    localparam logic [FILL_W-1:0] PIX_BYTES_F = FILL_W'(PIX_BYTES);
    localparam logic [FILL_W-1:0] RDY_LIMIT   = FILL_W'(BUF_BYTES - PIX_BYTES);
    localparam logic [3:0]        MAX_LANES_4 = 4'(MAX_LANES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BE     = 3'd1;
    localparam logic [2:0] S_ACTIVE = 3'd2;
    localparam logic [2:0] S_PAD    = 3'd3;
    localparam logic [2:0] S_BSYM   = 3'd4;

    logic [2:0]             r_state;
    logic [BUF_W-1:0]       r_buf;
    logic [FILL_W-1:0]      r_fill;
    logic                   r_last_seen;
    logic [LCNT_W-1:0]      r_lanes;
    logic                   r_pix_rdy;
    logic [MAX_LANES*8-1:0] r_lane_sym;
    logic [MAX_LANES-1:0]   r_lane_ctrl;
    logic                   r_sym_vld;

    logic [3:0]             w_req_lanes;
    logic [LCNT_W-1:0]      w_sel_lanes;
    logic [FILL_W-1:0]      w_lanes_f;
    logic                   w_push;
    logic                   w_start;
    logic [FILL_W-1:0]      w_pop_cnt;
    logic [FILL_W-1:0]      w_base;
    logic [FILL_W-1:0]      w_fill_next;
    logic                   w_last_next;
    logic [2:0]             w_state_next;
    logic                   w_rdy_next;
    logic                   w_vld_next;
    logic [BUF_W-1:0]       w_shifted;
    logic [BUF_W-1:0]       w_ins;
    logic [BUF_W-1:0]       w_mask;
    logic [BUF_W-1:0]       w_buf_next;
    logic [MAX_LANES*8-1:0] w_sym_next;
    logic [MAX_LANES-1:0]   w_ctrl_next;

    assign w_req_lanes = 4'd1 << lane_sel;
    assign w_sel_lanes = (w_req_lanes > MAX_LANES_4) ? LCNT_W'(MAX_LANES) : LCNT_W'(w_req_lanes);
    assign w_lanes_f   = FILL_W'(r_lanes);
    assign w_push      = pix_vld & r_pix_rdy;
    assign w_start     = (r_state == S_IDLE) & steer_en & pix_vld;

    // Next state looks at the post-pop fill so the last data beat runs straight into PAD/BS without a bubble.
    always_comb begin
        w_state_next = r_state;
        w_pop_cnt    = '0;
        w_vld_next   = 1'b0;
        w_last_next  = r_last_seen | (w_push & pix_last);
        case (r_state)
            S_IDLE: begin
                w_last_next = 1'b0;
                if (w_start) w_state_next = S_BE;
            end
            S_BE: begin
                w_vld_next   = 1'b1;
                w_state_next = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (r_fill >= w_lanes_f) begin
                    w_pop_cnt  = w_lanes_f;
                    w_vld_next = 1'b1;
                end
            end
            S_PAD: begin
                w_pop_cnt    = r_fill;
                w_vld_next   = 1'b1;
                w_state_next = S_BSYM;
            end
            S_BSYM: begin
                w_vld_next   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        w_fill_next = r_fill - w_pop_cnt + (w_push ? PIX_BYTES_F : '0);
        if (r_state == S_ACTIVE && w_last_next) begin
            if (w_fill_next == '0)
                w_state_next = S_BSYM;
            else if (w_fill_next < w_lanes_f)
                w_state_next = S_PAD;
        end
        w_rdy_next = ((w_state_next == S_BE) || (w_state_next == S_ACTIVE)) &&
                     !w_last_next && (w_fill_next <= RDY_LIMIT);
    end

    // Byte 0 of the buffer is always the next byte to send; pushes land just above what survives the pop.
    assign w_base     = r_fill - w_pop_cnt;
    assign w_shifted  = r_buf >> {w_pop_cnt, 3'b000};
    assign w_ins      = BUF_W'(pix_data) << {w_base, 3'b000};
    assign w_mask     = BUF_W'({PIX_W{1'b1}}) << {w_base, 3'b000};
    assign w_buf_next = w_push ? ((w_shifted & ~w_mask) | w_ins) : w_shifted;

    generate
        for (genvar gi = 0; gi < MAX_LANES; gi++) begin : g_lane
            logic       w_in_l;
            logic       w_in_f;
            logic [7:0] w_sym;
            logic       w_ctrl;

            assign w_in_l = LCNT_W'(gi) < r_lanes;
            assign w_in_f = FILL_W'(gi) < r_fill;

            always_comb begin
                w_sym  = 8'h00;
                w_ctrl = 1'b0;
                case (r_state)
                    S_BE: if (w_in_l) begin
                        w_sym  = SYM_BE;
                        w_ctrl = 1'b1;
                    end
                    S_ACTIVE: if (w_in_l && (r_fill >= w_lanes_f)) w_sym = r_buf[gi*8 +: 8];
                    S_PAD:    if (w_in_f) w_sym = r_buf[gi*8 +: 8];
                    S_BSYM: if (w_in_l) begin
                        w_sym  = SYM_BS;
                        w_ctrl = 1'b1;
                    end
                    default: ;
                endcase
            end

            assign w_sym_next[gi*8 +: 8] = w_sym;
            assign w_ctrl_next[gi]       = w_ctrl;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_buf       <= '0;
            r_fill      <= '0;
            r_last_seen <= 1'b0;
            r_lanes     <= LCNT_W'(1);
            r_pix_rdy   <= 1'b0;
            r_lane_sym  <= '0;
            r_lane_ctrl <= '0;
            r_sym_vld   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_buf       <= w_buf_next;
            r_fill      <= w_fill_next;
            r_last_seen <= w_last_next;
            if (w_start) r_lanes <= w_sel_lanes;
            r_pix_rdy   <= w_rdy_next;
            r_lane_sym  <= w_sym_next;
            r_lane_ctrl <= w_ctrl_next;
            r_sym_vld   <= w_vld_next;
        end
    end

`ifdef ISO_STEER_UNDERRUN_CNT_EN
    logic        w_underrun;
    logic [15:0] r_underrun_cnt;

    assign w_underrun = (r_state == S_ACTIVE) && (r_fill < w_lanes_f) && !r_last_seen;

    always_ff @(posedge clk) begin
        if (rst || w_start)
            r_underrun_cnt <= '0;
        else if (w_underrun && (r_underrun_cnt != 16'hFFFF))
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end

    assign underrun_cnt = r_underrun_cnt;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && (r_fill > RDY_LIMIT)));

    assign pix_rdy   = r_pix_rdy;
    assign lane_sym  = r_lane_sym;
    assign lane_ctrl = r_lane_ctrl;
    assign sym_vld   = r_sym_vld;
    assign line_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_iso_lane_steer_gen2.sv
// Directed bench for iso_lane_steer_gen2 (PIX_W=48, MAX_LANES=4): records lane output every cycle and
// compares each line's valid symbol stream and bubble count against hand-written expectations.
module tb_iso_lane_steer_gen2;

    logic        clk = 1'b0;
    logic        rst;
    logic        steer_en;
    logic [1:0]  lane_sel;
    logic [47:0] pix_data;
    logic        pix_vld;
    logic        pix_last;
    logic        pix_rdy;
    logic [31:0] lane_sym;
    logic [3:0]  lane_ctrl;
    logic        sym_vld;
    logic        line_busy;
`ifdef ISO_STEER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    always #5 clk = ~clk;

    iso_lane_steer_gen2 #(
        .PIX_W     (48),
        .MAX_LANES (4),
        .SYM_BE    (8'hFB),
        .SYM_BS    (8'hBC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .steer_en  (steer_en),
        .lane_sel  (lane_sel),
        .pix_data  (pix_data),
        .pix_vld   (pix_vld),
        .pix_last  (pix_last),
        .pix_rdy   (pix_rdy),
        .lane_sym  (lane_sym),
        .lane_ctrl (lane_ctrl),
        .sym_vld   (sym_vld),
`ifdef ISO_STEER_UNDERRUN_CNT_EN
        .underrun_cnt (underrun_cnt),
`endif
        .line_busy (line_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] log_sym  [1024];
    logic [3:0]  log_ctrl [1024];
    logic        log_vld  [1024];
    int          log_n = 0;

    always @(negedge clk) begin
        if (log_n < 1024) begin
            log_sym[log_n]  <= lane_sym;
            log_ctrl[log_n] <= lane_ctrl;
            log_vld[log_n]  <= sym_vld;
            log_n           <= log_n + 1;
        end
    end

    logic [31:0] exp_sym  [32];
    logic [3:0]  exp_ctrl [32];
    int          exp_n;

    localparam logic [47:0] W1 = 48'h060504030201;
    localparam logic [47:0] W2 = 48'h0C0B0A090807;
    localparam logic [47:0] W3 = 48'h1211100F0E0D;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic add_exp(input logic [31:0] s, input logic [3:0] c);
        exp_sym[exp_n]  = s;
        exp_ctrl[exp_n] = c;
        exp_n++;
    endtask

    task automatic send(input logic [47:0] d, input logic last);
        int   n;
        logic ok;
        n = 0;
        ok = 1'b0;
        pix_data = d;
        pix_last = last;
        pix_vld  = 1'b1;
        do begin
            ok = pix_rdy;
            tick();
            n++;
        end while (!ok && n < 50);
        pix_vld  = 1'b0;
        pix_last = 1'b0;
        chk("send_accept", 64'(ok), 64'd1);
        $display("xfer data=%h last=%0d cycles=%0d", d, last, n);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (line_busy && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 64'(line_busy), 64'd0);
        tick();
        tick();
    endtask

    task automatic check_log(input string tag, input int start, input int stop, input int exp_gaps);
        int k;
        int first;
        int last;
        k = 0;
        first = -1;
        last = -1;
        for (int i = start; i < stop; i++) begin
            if (log_vld[i] === 1'b1) begin
                if (first < 0) first = i;
                last = i;
                if (k < exp_n) begin
                    chk($sformatf("%s_sym%0d", tag, k), 64'(log_sym[i]), 64'(exp_sym[k]));
                    chk($sformatf("%s_ctrl%0d", tag, k), 64'(log_ctrl[i]), 64'(exp_ctrl[k]));
                end
                k++;
            end
        end
        chk({tag, "_count"}, 64'(k), 64'(exp_n));
        chk({tag, "_gaps"}, 64'((first < 0) ? 0 : (last - first + 1 - k)), 64'(exp_gaps));
        $display("line %s: %0d symbols", tag, k);
    endtask

    task automatic exp_two_word_4lane();
        exp_n = 0;
        add_exp(32'hFBFBFBFB, 4'hF);
        add_exp(32'h04030201, 4'h0);
        add_exp(32'h08070605, 4'h0);
        add_exp(32'h0C0B0A09, 4'h0);
        add_exp(32'hBCBCBCBC, 4'hF);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int start;

        rst      = 1'b1;
        steer_en = 1'b0;
        lane_sel = 2'd0;
        pix_data = '0;
        pix_vld  = 1'b0;
        pix_last = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_sym",  64'(lane_sym),  64'd0);
        chk("rst_ctrl", 64'(lane_ctrl), 64'd0);
        chk("rst_vld",  64'(sym_vld),   64'd0);
        chk("rst_rdy",  64'(pix_rdy),   64'd0);
        chk("rst_busy", 64'(line_busy), 64'd0);

        // Test 1: two words over four lanes
        start = log_n;
        lane_sel = 2'd2;
        steer_en = 1'b1;
        send(W1, 1'b0);
        steer_en = 1'b0;
        send(W2, 1'b1);
        wait_idle("t1");
        exp_two_word_4lane();
        check_log("t1", start, log_n, 0);
        chk("t1_after_vld", 64'(sym_vld), 64'd0);
`ifdef ISO_STEER_UNDERRUN_CNT_EN
        chk("t1_underrun_cnt", 64'(underrun_cnt), 64'd0);
`endif

        // Test 2: single lane, one word
        start = log_n;
        lane_sel = 2'd0;
        steer_en = 1'b1;
        send(W1, 1'b1);
        steer_en = 1'b0;
        wait_idle("t2");
        exp_n = 0;
        add_exp(32'h000000FB, 4'h1);
        for (int b = 1; b <= 6; b++) add_exp(32'(b), 4'h0);
        add_exp(32'h000000BC, 4'h1);
        check_log("t2", start, log_n, 0);

        // Test 3: four lanes, one word ends in a pad beat
        start = log_n;
        lane_sel = 2'd2;
        steer_en = 1'b1;
        send(W1, 1'b1);
        steer_en = 1'b0;
        wait_idle("t3");
        exp_n = 0;
        add_exp(32'hFBFBFBFB, 4'hF);
        add_exp(32'h04030201, 4'h0);
        add_exp(32'h00000605, 4'h0);
        add_exp(32'hBCBCBCBC, 4'hF);
        check_log("t3", start, log_n, 0);

        // Test 4: source stalls after the buffer drains -> three underrun bubbles
        start = log_n;
        lane_sel = 2'd2;
        steer_en = 1'b1;
        send(W1, 1'b0);
        steer_en = 1'b0;
        send(W2, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        send(W3, 1'b1);
        wait_idle("t4");
        exp_two_word_4lane();
        exp_n = 4;
        add_exp(32'h100F0E0D, 4'h0);
        add_exp(32'h00001211, 4'h0);
        add_exp(32'hBCBCBCBC, 4'hF);
        check_log("t4", start, log_n, 3);
`ifdef ISO_STEER_UNDERRUN_CNT_EN
        chk("t4_underrun_cnt", 64'(underrun_cnt), 64'd3);
`endif

        // Test 5: reset mid-line abandons it without a BS
        lane_sel = 2'd2;
        steer_en = 1'b1;
        send(W1, 1'b0);
        steer_en = 1'b0;
        send(W2, 1'b0);
        chk("t5_busy_before", 64'(line_busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_sym",  64'(lane_sym),  64'd0);
        chk("t5_ctrl", 64'(lane_ctrl), 64'd0);
        chk("t5_vld",  64'(sym_vld),   64'd0);
        chk("t5_rdy",  64'(pix_rdy),   64'd0);
        chk("t5_busy", 64'(line_busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5_quiet_vld%0d", i), 64'(sym_vld), 64'd0);
        end
        start = log_n;
        steer_en = 1'b1;
        send(W1, 1'b0);
        steer_en = 1'b0;
        send(W2, 1'b1);
        wait_idle("t5b");
        exp_two_word_4lane();
        check_log("t5b", start, log_n, 0);

        // Test 6: lane_sel=3 clips to four lanes; a mid-line lane_sel change is ignored
        start = log_n;
        lane_sel = 2'd3;
        steer_en = 1'b1;
        send(W1, 1'b0);
        steer_en = 1'b0;
        lane_sel = 2'd0;
        send(W2, 1'b1);
        wait_idle("t6");
        exp_two_word_4lane();
        check_log("t6", start, log_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
